// File: rtl/gpu_rect_engine_if.sv
// Command and pixel-stream bundle for gpu_rect_engine.
// slave = engine side, master = command issuer / pixel sink side.
interface gpu_rect_engine_if #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
);
  logic [WIDTH_BITS-1:0]   x1_i, x2_i;
  logic [HEIGHT_BITS-1:0]  y1_i, y2_i;
  logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic                    mode_i;
  logic                    start_i;
  logic                    abort_i;
  logic                    pix_ready_i;
  logic [WIDTH_BITS-1:0]   x_o;
  logic [HEIGHT_BITS-1:0]  y_o;
  logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
  logic                    pix_valid_o;
  logic                    busy_o;
  logic                    done_o;

  modport slave (
    input  x1_i, x2_i, y1_i, y2_i, r_i, g_i, b_i, mode_i, start_i, abort_i, pix_ready_i,
    output x_o, y_o, r_o, g_o, b_o, pix_valid_o, busy_o, done_o
  );

  modport master (
    output x1_i, x2_i, y1_i, y2_i, r_i, g_i, b_i, mode_i, start_i, abort_i, pix_ready_i,
    input  x_o, y_o, r_o, g_o, b_o, pix_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/gpu_rect_engine.sv
// Rectangle rasteriser: clips a corner pair to the screen and streams its pixels in raster order.
// Optional outline mode is compiled in by defining GPU_RECT_OUTLINE_EN.
module gpu_rect_engine #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480
) (
  input  logic             clk,
  input  logic             n_rst,
  gpu_rect_engine_if.slave bus,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(SCREEN_H - 1);

  state_t                 state;
  logic [WIDTH_BITS-1:0]  x1_q, x2_q, xmin_q, xmax_q;
  logic [HEIGHT_BITS-1:0] y1_q, y2_q, ymin_q, ymax_q;
  logic [WIDTH_BITS-1:0]  xlo, xhi_raw, xhi;
  logic [HEIGHT_BITS-1:0] ylo, yhi_raw, yhi;
  logic                   off_screen, row_end, last_px, skip_interior;
  logic                   outline_q;

  // Normalise the latched corners and clip the far edge to the last visible pixel.
  assign xlo        = (x1_q < x2_q) ? x1_q : x2_q;
  assign xhi_raw    = (x1_q < x2_q) ? x2_q : x1_q;
  assign xhi        = (xhi_raw > X_LAST) ? X_LAST : xhi_raw;
  assign ylo        = (y1_q < y2_q) ? y1_q : y2_q;
  assign yhi_raw    = (y1_q < y2_q) ? y2_q : y1_q;
  assign yhi        = (yhi_raw > Y_LAST) ? Y_LAST : yhi_raw;
  assign off_screen = (xlo > X_LAST) || (ylo > Y_LAST);

  assign row_end       = (bus.x_o == xmax_q);
  assign last_px       = row_end && (bus.y_o == ymax_q);
  // Interior rows of an outline only carry the two side pixels.
  assign skip_interior = outline_q && (bus.y_o != ymin_q) && (bus.y_o != ymax_q)
                         && (bus.x_o == xmin_q);

  assign state_dbg = state;

`ifdef GPU_RECT_OUTLINE_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outline_q <= 1'b0;
    end else if (state == IDLE && bus.start_i) begin
      outline_q <= bus.mode_i;
    end
  end
`else
  assign outline_q = 1'b0;
`endif

  // Stream: a pixel transfers on a rising edge with pix_valid_o && pix_ready_i;
  // while pix_valid_o is high and pix_ready_i low, x_o/y_o/colour hold unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      x1_q            <= '0;
      x2_q            <= '0;
      y1_q            <= '0;
      y2_q            <= '0;
      xmin_q          <= '0;
      xmax_q          <= '0;
      ymin_q          <= '0;
      ymax_q          <= '0;
      bus.x_o         <= '0;
      bus.y_o         <= '0;
      bus.r_o         <= '0;
      bus.g_o         <= '0;
      bus.b_o         <= '0;
      bus.pix_valid_o <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.done_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            x1_q       <= bus.x1_i;
            x2_q       <= bus.x2_i;
            y1_q       <= bus.y1_i;
            y2_q       <= bus.y2_i;
            bus.r_o    <= bus.r_i;
            bus.g_o    <= bus.g_i;
            bus.b_o    <= bus.b_i;
            bus.busy_o <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (bus.abort_i) begin
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end else if (off_screen) begin
            bus.done_o <= 1'b1;
            state      <= DONE;
          end else begin
            xmin_q          <= xlo;
            xmax_q          <= xhi;
            ymin_q          <= ylo;
            ymax_q          <= yhi;
            bus.x_o         <= xlo;
            bus.y_o         <= ylo;
            bus.pix_valid_o <= 1'b1;
            state           <= RUN;
          end
        end
        RUN: begin
          if (bus.abort_i) begin
            bus.pix_valid_o <= 1'b0;
            bus.busy_o      <= 1'b0;
            state           <= IDLE;
          end else if (bus.pix_ready_i) begin
            if (last_px) begin
              bus.pix_valid_o <= 1'b0;
              bus.done_o      <= 1'b1;
              state           <= DONE;
            end else if (row_end) begin
              bus.x_o <= xmin_q;
              bus.y_o <= bus.y_o + HEIGHT_BITS'(1);
            end else if (skip_interior) begin
              bus.x_o <= xmax_q;
            end else begin
              bus.x_o <= bus.x_o + WIDTH_BITS'(1);
            end
          end
        end
        DONE: begin
          bus.done_o <= 1'b0;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_rect_engine.sv
// Self-checking bench for gpu_rect_engine: directed vector table, random commands against a
// pixel-list reference model, and hand-written abort / reset sequences.
module tb_gpu_rect_engine;
  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 8;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int PW = WB + HB;
`ifdef GPU_RECT_OUTLINE_EN
  localparam bit OUTLINE_BUILD = 1'b1;
`else
  localparam bit OUTLINE_BUILD = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic [1:0] state_dbg;

  gpu_rect_engine_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) rif ();

  gpu_rect_engine #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (rif),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: list every pixel of the clipped rectangle in raster order.
  task automatic build_exp(input int x1, input int y1, input int x2, input int y2, input bit mode);
    int xl, xh, yl, yh;
    bit outline;
    logic [WB-1:0] px;
    logic [HB-1:0] py;
    exp_q.delete();
    xl = (x1 < x2) ? x1 : x2;
    xh = (x1 < x2) ? x2 : x1;
    yl = (y1 < y2) ? y1 : y2;
    yh = (y1 < y2) ? y2 : y1;
    if (xh > SW - 1) xh = SW - 1;
    if (yh > SH - 1) yh = SH - 1;
    outline = OUTLINE_BUILD && mode;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (!outline || x == xl || x == xh || y == yl || y == yh) begin
          px = WB'(x);
          py = HB'(y);
          exp_q.push_back({px, py});
        end
      end
    end
  endtask

  // driver: call at a negedge; leaves the bench at a negedge with the engine idle
  task automatic run_cmd(input int x1, input int y1, input int x2, input int y2, input bit mode,
                         input int ready_mode, output int n_xfer, output logic [PW-1:0] last_px);
    logic [CB-1:0] cr, cg, cb;
    logic [PW-1:0] px;
    int n_exp, cyc, stalls, budget, k;
    int pat[4];
    bit seen_done, rdy;
    pat = '{1, 0, 0, 1};
    build_exp(x1, y1, x2, y2, mode);
    n_exp = exp_q.size();
    cr = CB'($urandom_range(0, 255));
    cg = CB'($urandom_range(0, 255));
    cb = CB'($urandom_range(0, 255));
    rif.x1_i = WB'(x1);
    rif.y1_i = HB'(y1);
    rif.x2_i = WB'(x2);
    rif.y2_i = HB'(y2);
    rif.r_i = cr;
    rif.g_i = cg;
    rif.b_i = cb;
    rif.mode_i = mode;
    rif.start_i = 1'b1;
    rif.pix_ready_i = 1'b1;
    n_xfer = 0;
    last_px = '0;
    stalls = 0;
    cyc = 0;
    k = 0;
    seen_done = 1'b0;
    budget = 4 * n_exp + 20;
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      rif.abort_i = 1'b0;
      // stray starts with garbage coordinates must not disturb the running command
      rif.start_i = (ready_mode == 1) && ($urandom_range(0, 7) == 0);
      rif.x1_i = WB'($urandom_range(0, 1023));
      rif.y2_i = HB'($urandom_range(0, 511));
      rif.r_i = CB'($urandom_range(0, 255));
      rif.g_i = CB'($urandom_range(0, 255));
      rif.b_i = CB'($urandom_range(0, 255));
      if (cyc == 1) begin
        check("setup_busy", rif.busy_o, 1);
        check("setup_valid", rif.pix_valid_o, 0);
      end
      if (cyc == 2 && n_exp > 0) check("first_valid_latency", rif.pix_valid_o, 1);
      if (rif.pix_valid_o) begin
        px = {rif.x_o, rif.y_o};
        if (exp_q.size() == 0) check("pixel_overrun", n_xfer + 1, n_exp);
        else check("pixel_xy", px, exp_q[0]);
        check("pixel_colour", {rif.r_o, rif.g_o, rif.b_o}, {cr, cg, cb});
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = bit'($urandom_range(0, 1));
          default: rdy = bit'(pat[k % 4]);
        endcase
        k++;
        rif.pix_ready_i = rdy;
        if (rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n_xfer++;
          last_px = px;
        end else begin
          stalls++;
        end
      end
      if (rif.done_o) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, (n_exp == 0) ? 2 : 2 + n_exp + stalls);
      end
    end
    if (!seen_done) check("done_timeout", cyc, budget + 1);
    check("expected_left", exp_q.size(), 0);
    @(negedge clk);
    rif.start_i = 1'b0;
    check("done_one_cycle", rif.done_o, 0);
    check("idle_busy", rif.busy_o, 0);
    check("idle_state", state_dbg, 0);
  endtask

  typedef struct {
    int x1, y1, x2, y2;
    bit mode;
    int exp_n, lx, ly;
  } vec_t;

  vec_t vecs[12];
  int n;
  logic [PW-1:0] lp;
  logic [PW-1:0] want_last;
  int rx1, ry1, rx2, ry2;

  initial begin
    vecs[0]  = '{2, 3, 4, 4, 1'b0, 6, 4, 4};
    vecs[1]  = '{4, 4, 2, 3, 1'b0, 6, 4, 4};
    vecs[2]  = '{630, 470, 700, 500, 1'b0, 100, 639, 479};
    vecs[3]  = '{700, 10, 710, 20, 1'b0, 0, 0, 0};
    vecs[4]  = '{5, 5, 5, 5, 1'b0, 1, 5, 5};
    vecs[5]  = '{0, 7, 9, 7, 1'b0, 10, 9, 7};
    vecs[6]  = '{12, 2, 12, 8, 1'b0, 7, 12, 8};
    vecs[7]  = '{0, 0, 3, 3, 1'b1, OUTLINE_BUILD ? 12 : 16, 3, 3};
    vecs[8]  = '{639, 479, 639, 479, 1'b0, 1, 639, 479};
    vecs[9]  = '{10, 480, 20, 490, 1'b0, 0, 0, 0};
    vecs[10] = '{2, 1, 6, 5, 1'b1, OUTLINE_BUILD ? 16 : 25, 6, 5};
    vecs[11] = '{20, 40, 20, 40, 1'b1, 1, 20, 40};

    n_rst = 1'b0;
    rif.x1_i = '0; rif.x2_i = '0; rif.y1_i = '0; rif.y2_i = '0;
    rif.r_i = '0; rif.g_i = '0; rif.b_i = '0;
    rif.mode_i = 1'b0; rif.start_i = 1'b0; rif.abort_i = 1'b0; rif.pix_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rif.pix_valid_o, 0);
    check("rst_busy", rif.busy_o, 0);
    check("rst_done", rif.done_o, 0);
    check("rst_xy", {rif.x_o, rif.y_o}, 0);
    check("rst_rgb", {rif.r_o, rif.g_o, rif.b_o}, 0);
    check("rst_state", state_dbg, 0);

    // start right after reset release
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      want_last = {WB'(vecs[i].lx), HB'(vecs[i].ly)};
      run_cmd(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].mode, i % 3, n, lp);
      check("vec_count", n, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) check("vec_last", lp, want_last);
    end

    // abort asserted together with start in IDLE is ignored
    rif.abort_i = 1'b1;
    run_cmd(1, 1, 3, 2, 1'b0, 0, n, lp);
    check("idle_abort_count", n, 6);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx1 = $urandom_range(620, 1023); rx2 = $urandom_range(620, 1023);
        ry1 = $urandom_range(465, 511);  ry2 = $urandom_range(465, 511);
      end else begin
        rx1 = $urandom_range(0, 15); rx2 = $urandom_range(0, 15);
        ry1 = $urandom_range(0, 12); ry2 = $urandom_range(0, 12);
      end
      run_cmd(rx1, ry1, rx2, ry2, bit'($urandom_range(0, 1)), $urandom_range(0, 2), n, lp);
    end

    // abort after the third transfer of a 10x10 fill
    rif.x1_i = 10'd0; rif.y1_i = 9'd0; rif.x2_i = 10'd9; rif.y2_i = 9'd9;
    rif.mode_i = 1'b0; rif.pix_ready_i = 1'b1; rif.start_i = 1'b1;
    @(negedge clk);
    rif.start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_x", rif.x_o, 3);
    rif.abort_i = 1'b1;
    @(negedge clk);
    rif.abort_i = 1'b0;
    check("abort_valid", rif.pix_valid_o, 0);
    check("abort_busy", rif.busy_o, 0);
    check("abort_done", rif.done_o, 0);
    check("abort_state", state_dbg, 0);
    @(negedge clk);
    check("abort_no_done", rif.done_o, 0);

    // abort while in SETUP
    rif.start_i = 1'b1;
    @(negedge clk);
    rif.start_i = 1'b0;
    check("setup_abort_busy_before", rif.busy_o, 1);
    rif.abort_i = 1'b1;
    @(negedge clk);
    rif.abort_i = 1'b0;
    check("setup_abort_busy", rif.busy_o, 0);
    check("setup_abort_valid", rif.pix_valid_o, 0);
    @(negedge clk);
    check("setup_abort_no_done", rif.done_o, 0);

    // reset pulse mid-RUN
    rif.r_i = 8'hA5; rif.g_i = 8'h5A; rif.b_i = 8'h3C;
    rif.start_i = 1'b1;
    @(negedge clk);
    rif.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", rif.pix_valid_o, 1);
    n_rst = 1'b0;
    #1;
    check("midrst_valid", rif.pix_valid_o, 0);
    check("midrst_busy", rif.busy_o, 0);
    check("midrst_xy", {rif.x_o, rif.y_o}, 0);
    check("midrst_rgb", {rif.r_o, rif.g_o, rif.b_o}, 0);
    check("midrst_state", state_dbg, 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_cmd(2, 3, 4, 4, 1'b0, 2, n, lp);
    check("post_rst_count", n, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
